// File: rtl/seg_seq_checker.sv
// Read-back monitor for a four-digit active-low 7-segment bus: decodes each
// sampled frame and tracks the 6-phase walk-in sequence. Optional debug taps: SEG_CHECK_DEBUG_EN.
module seg_seq_checker #(
   parameter logic [3:0] D3 = 4'h5,
   parameter logic [3:0] D2 = 4'h0,
   parameter logic [3:0] D1 = 4'h7,
   parameter logic [3:0] D0 = 4'h2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sample,
   input  logic [6:0] ss3,
   input  logic [6:0] ss2,
   input  logic [6:0] ss1,
   input  logic [6:0] ss0,
   output logic       locked,
   output logic       err,
   output logic [7:0] err_count,
   output logic [7:0] cycle_count
`ifdef SEG_CHECK_DEBUG_EN
   ,
   output logic [15:0] dbg_digits,
   output logic [3:0]  dbg_blank
`endif
);

   typedef enum logic [2:0] {
      HUNT = 3'd0,
      S0   = 3'd1,
      S1   = 3'd2,
      S2   = 3'd3,
      S3   = 3'd4,
      S4   = 3'd5,
      S5   = 3'd6
   } state_t;

   // Returns {valid, blank, value}; invalid patterns report value F.
   function automatic logic [5:0] seg_decode(input logic [6:0] seg);
      logic [5:0] r;
      case (seg)
         7'b1111111: r = {2'b11, 4'h0};
         7'b1000000: r = {2'b10, 4'h0};
         7'b1111001: r = {2'b10, 4'h1};
         7'b0100100: r = {2'b10, 4'h2};
         7'b0110000: r = {2'b10, 4'h3};
         7'b0011001: r = {2'b10, 4'h4};
         7'b0010010: r = {2'b10, 4'h5};
         7'b0000010: r = {2'b10, 4'h6};
         7'b1111000: r = {2'b10, 4'h7};
         7'b0000000: r = {2'b10, 4'h8};
         7'b0010000: r = {2'b10, 4'h9};
         7'b0001000: r = {2'b10, 4'hA};
         7'b0000011: r = {2'b10, 4'hB};
         7'b1000110: r = {2'b10, 4'hC};
         7'b0100001: r = {2'b10, 4'hD};
         7'b0000110: r = {2'b10, 4'hE};
         7'b0001110: r = {2'b10, 4'hF};
         default:    r = {2'b00, 4'hF};
      endcase
      return r;
   endfunction

   logic [3:0][6:0] ss_all;
   logic [3:0][3:0] exp_val;
   logic [3:0][5:0] dec;
   logic [3:0][3:0] dig_val;
   logic [3:0]      dig_blank;
   logic [3:0]      dig_hex;
   logic [3:0]      val_ok;
   logic [3:0]      only_ok;
   logic            all_blank;
   logic            full_ok;

   assign ss_all  = {ss3, ss2, ss1, ss0};
   assign exp_val = {D3, D2, D1, D0};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_digit
         localparam logic [3:0] SELF_MASK = 4'(1 << gi);
         assign dec[gi]       = seg_decode(ss_all[gi]);
         assign dig_val[gi]   = dec[gi][3:0];
         assign dig_blank[gi] = dec[gi][4];
         assign dig_hex[gi]   = dec[gi][5] & ~dec[gi][4];
         assign val_ok[gi]    = dig_hex[gi] && (dig_val[gi] == exp_val[gi]);
         // This digit carries its expected value and every other digit is blank.
         assign only_ok[gi]   = val_ok[gi] & (&(dig_blank | SELF_MASK));
      end
   endgenerate

   assign all_blank = &dig_blank;
   assign full_ok   = &val_ok;

   state_t     state_q, state_d;
   logic       locked_q, locked_d;
   logic       err_q, err_d;
   logic [7:0] err_cnt_q, err_cnt_d;
   logic [7:0] cyc_cnt_q, cyc_cnt_d;

   always_comb begin
      logic   in_seq;
      logic   frame_ok;
      state_t seq_next;

      state_d   = state_q;
      locked_d  = locked_q;
      err_d     = 1'b0;
      err_cnt_d = err_cnt_q;
      cyc_cnt_d = cyc_cnt_q;
      in_seq    = 1'b1;
      frame_ok  = 1'b0;
      seq_next  = HUNT;

      case (state_q)
         S0: begin frame_ok = all_blank;  seq_next = S1; end
         S1: begin frame_ok = only_ok[3]; seq_next = S2; end
         S2: begin frame_ok = only_ok[2]; seq_next = S3; end
         S3: begin frame_ok = only_ok[1]; seq_next = S4; end
         S4: begin frame_ok = only_ok[0]; seq_next = S5; end
         S5: begin frame_ok = full_ok;    seq_next = S0; end
         default: in_seq = 1'b0;
      endcase

      if (sample) begin
         if (!in_seq) begin
            state_d = all_blank ? S1 : HUNT;
         end else if (frame_ok) begin
            state_d = seq_next;
            if (state_q == S5) begin
               cyc_cnt_d = cyc_cnt_q + 8'd1;
               locked_d  = 1'b1;
            end
         end else begin
            // A blank mismatching frame is itself a valid S0, so resync immediately.
            state_d  = all_blank ? S1 : HUNT;
            err_d    = 1'b1;
            locked_d = 1'b0;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= HUNT;
         locked_q  <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= 8'd0;
         cyc_cnt_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         locked_q  <= locked_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
         cyc_cnt_q <= cyc_cnt_d;
      end
   end

   assign locked      = locked_q;
   assign err         = err_q;
   assign err_count   = err_cnt_q;
   assign cycle_count = cyc_cnt_q;

`ifdef SEG_CHECK_DEBUG_EN
   logic [15:0] dbg_digits_q;
   logic [3:0]  dbg_blank_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dbg_digits_q <= 16'h0000;
         dbg_blank_q  <= 4'b0000;
      end else if (sample) begin
         dbg_digits_q <= {dig_val[3], dig_val[2], dig_val[1], dig_val[0]};
         dbg_blank_q  <= dig_blank;
      end
   end

   assign dbg_digits = dbg_digits_q;
   assign dbg_blank  = dbg_blank_q;
`endif

endmodule

// File: tb/tb_seg_seq_checker.sv
// Directed bench for seg_seq_checker: walk-in sequence, mismatch handling,
// sample gating, error saturation and asynchronous reset.
module tb_seg_seq_checker;

   localparam logic [6:0] BL = 7'b1111111;
   localparam logic [6:0] P5 = 7'b0010010;
   localparam logic [6:0] P0 = 7'b1000000;
   localparam logic [6:0] P7 = 7'b1111000;
   localparam logic [6:0] P2 = 7'b0100100;
   localparam logic [6:0] GB = 7'b0101010;

   logic       clk;
   logic       rst;
   logic       sample;
   logic [6:0] ss3, ss2, ss1, ss0;
   logic       locked;
   logic       err;
   logic [7:0] err_count;
   logic [7:0] cycle_count;
`ifdef SEG_CHECK_DEBUG_EN
   logic [15:0] dbg_digits;
   logic [3:0]  dbg_blank;
`endif

   int n_checks = 0;
   int n_errors = 0;

   seg_seq_checker dut (
      .clk         (clk),
      .rst         (rst),
      .sample      (sample),
      .ss3         (ss3),
      .ss2         (ss2),
      .ss1         (ss1),
      .ss0         (ss0),
      .locked      (locked),
      .err         (err),
      .err_count   (err_count),
      .cycle_count (cycle_count)
`ifdef SEG_CHECK_DEBUG_EN
      ,
      .dbg_digits  (dbg_digits),
      .dbg_blank   (dbg_blank)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   // Present one frame with sample high for exactly one rising edge.
   task automatic send_frame(input logic [6:0] a3, input logic [6:0] a2,
                             input logic [6:0] a1, input logic [6:0] a0);
      ss3 = a3; ss2 = a2; ss1 = a1; ss0 = a0;
      sample = 1'b1;
      @(posedge clk);
      #1;
      sample = 1'b0;
   endtask

   task automatic full_cycle(input logic chk);
      send_frame(BL, BL, BL, BL);
      if (chk) check("walk_s0_err", err, 0);
      send_frame(P5, BL, BL, BL);
      if (chk) check("walk_s1_err", err, 0);
      send_frame(BL, P0, BL, BL);
      if (chk) check("walk_s2_err", err, 0);
      send_frame(BL, BL, P7, BL);
      if (chk) check("walk_s3_err", err, 0);
      send_frame(BL, BL, BL, P2);
      if (chk) check("walk_s4_err", err, 0);
      if (chk) check("walk_s4_locked", locked, 0);
      send_frame(P5, P0, P7, P2);
      if (chk) check("walk_s5_err", err, 0);
   endtask

   initial begin
      rst = 1'b1; sample = 1'b0;
      ss3 = BL; ss2 = BL; ss1 = BL; ss0 = BL;
      #12;
      check("rst_locked", locked, 0);
      check("rst_err", err, 0);
      check("rst_err_count", err_count, 0);
      check("rst_cycle_count", cycle_count, 0);
      rst = 1'b0;

      // First walk-in locks.
      full_cycle(1'b1);
      check("lock1_locked", locked, 1);
      check("lock1_cycle_count", cycle_count, 1);
`ifdef SEG_CHECK_DEBUG_EN
      check("dbg_digits_5072", dbg_digits, 16'h5072);
      check("dbg_blank_5072", dbg_blank, 4'b0000);
`endif

      full_cycle(1'b0);
      full_cycle(1'b0);
      check("clean3_cycle_count", cycle_count, 3);
      check("clean3_err_count", err_count, 0);

      // Wrong digit in S2 (7 instead of 0).
      send_frame(BL, BL, BL, BL);
`ifdef SEG_CHECK_DEBUG_EN
      check("dbg_blank_all", dbg_blank, 4'b1111);
`endif
      send_frame(P5, BL, BL, BL);
      send_frame(BL, P7, BL, BL);
      check("mm_err", err, 1);
      check("mm_err_count", err_count, 1);
      check("mm_locked", locked, 0);
      @(posedge clk); #1;
      check("mm_err_pulse_end", err, 0);
      // In HUNT a non-blank frame is ignored silently.
      send_frame(BL, P0, BL, BL);
      check("hunt_ignore_err", err, 0);
      check("hunt_ignore_count", err_count, 1);
      full_cycle(1'b0);
      check("relock_cycle_count", cycle_count, 4);
      check("relock_locked", locked, 1);
      check("relock_err_count", err_count, 1);

      // Garbage with sample low is ignored.
      for (int i = 0; i < 10; i++) begin
         ss3 = 7'($urandom); ss2 = 7'($urandom); ss1 = 7'($urandom); ss0 = 7'($urandom);
         @(posedge clk); #1;
         if (i == 0 || i == 9) check("idle_err", err, 0);
      end
      check("idle_locked", locked, 1);
      check("idle_err_count", err_count, 1);
      check("idle_cycle_count", cycle_count, 4);
      // Still at S0: a blank frame matches.
      send_frame(BL, BL, BL, BL);
      check("idle_resume_err", err, 0);

      // Now in S1: garbage mismatches -> HUNT, count 2.
      send_frame(GB, GB, GB, GB);
      check("sat_pre_err_count", err_count, 2);
      for (int i = 0; i < 260; i++) begin
         send_frame(BL, BL, BL, BL);
         if (i == 0) check("sat_blank_enter_err", err, 0);
         send_frame(GB, BL, GB, BL);
         if (i == 251) check("sat_err_count_254", err_count, 254);
         if (i == 252) check("sat_err_count_255", err_count, 255);
         if (i == 259) check("sat_last_err", err, 1);
      end
      check("sat_final_err_count", err_count, 255);
      check("sat_locked", locked, 0);

      // Lock again, then reset asynchronously while sitting in S3.
      full_cycle(1'b0);
      check("prerst_cycle_count", cycle_count, 5);
      check("prerst_locked", locked, 1);
      send_frame(BL, BL, BL, BL);
      send_frame(P5, BL, BL, BL);
      send_frame(BL, P0, BL, BL);
      #2;
      rst = 1'b1;
      #1;
      check("arst_locked", locked, 0);
      check("arst_err_count", err_count, 0);
      check("arst_cycle_count", cycle_count, 0);
      check("arst_err", err, 0);
      #1;
      rst = 1'b0;
      send_frame(BL, BL, BL, BL);
      check("post_rst_blank_err", err, 0);
      send_frame(P5, BL, BL, BL);
      check("post_rst_s1_err", err, 0);
      // Stuck display: the same S1 frame again is a mismatch.
      send_frame(P5, BL, BL, BL);
      check("stuck_err", err, 1);
      check("stuck_err_count", err_count, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
